// File: rtl/wb_pkg.sv
// Writeback-stage shared types: exception codes, rd select, and regfile write-port record.
// Shared with the regfile and mem stage.
package wb_pkg;

    typedef enum logic [4:0] {
        EXCEPT_MISALIGNED_FETCH = 5'd0,
        EXCEPT_FETCH_FAULT      = 5'd1,
        EXCEPT_ILLEGAL_INSTR    = 5'd2,
        EXCEPT_BREAKPOINT       = 5'd3,
        EXCEPT_MISALIGNED_LOAD  = 5'd4,
        EXCEPT_LOAD_FAULT       = 5'd5,
        EXCEPT_MISALIGNED_STORE = 5'd6,
        EXCEPT_STORE_FAULT      = 5'd7,
        EXCEPT_ECALL_FROM_U     = 5'd8,
        EXCEPT_ECALL_FROM_S     = 5'd9,
        EXCEPT_ECALL_FROM_M     = 5'd11,
        EXCEPT_MISPRED          = 5'd16,
        EXCEPT_MISPRED_NO_TRACE = 5'd17,
        EXCEPT_SYS              = 5'd18,
        EXCEPT_FLUSH            = 5'd19
    } except_code_t;

    typedef enum logic [1:0] {
        RD_NONE       = 2'd0,
        RD_REG        = 2'd1,
        RD_REG_AND_PC = 2'd2
    } rd_sel_t;

    localparam int unsigned ARCH_XLEN      = 32;
    localparam int unsigned ARCH_REG_IDX_W = 5;

    typedef struct packed {
        logic                      valid;
        logic [ARCH_REG_IDX_W-1:0] idx;
        logic [ARCH_XLEN-1:0]      data;
    } int_arch_reg_wb_t;

    // Codes whose instruction still completes (and may write rd) while redirecting.
    function automatic logic is_retiring_except(input logic [4:0] code);
        return (code == EXCEPT_MISPRED)      || (code == EXCEPT_MISPRED_NO_TRACE) ||
               (code == EXCEPT_SYS)          || (code == EXCEPT_FLUSH)            ||
               (code == EXCEPT_ECALL_FROM_M) || (code == EXCEPT_ECALL_FROM_S)     ||
               (code == EXCEPT_ECALL_FROM_U);
    endfunction

    function automatic logic is_mispred(input logic [4:0] code);
        return (code == EXCEPT_MISPRED) || (code == EXCEPT_MISPRED_NO_TRACE);
    endfunction

    function automatic int_arch_reg_wb_t compose_int_arch_reg_wb(
        input logic                      valid,
        input logic [ARCH_REG_IDX_W-1:0] idx,
        input logic [ARCH_XLEN-1:0]      data
    );
        int_arch_reg_wb_t r;
        r.valid = valid;
        r.idx   = idx;
        r.data  = data;
        return r;
    endfunction

endpackage

// File: rtl/wb_lane_sel.sv
// Oldest-excepting-lane priority encoder plus same-cycle WAW keep mask.
// Purely combinational; any LANES.
module wb_lane_sel #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned REG_IDX_W = 5
) (
    input  logic [LANES-1:0]           i_valid,
    input  logic [LANES-1:0]           i_except_valid,
    input  logic [LANES*REG_IDX_W-1:0] i_rd_idx,
    input  logic [LANES-1:0]           i_cand,
    output logic                       o_except_found,
    output logic [LANES-1:0]           o_except_oh,
    output logic [LANES-1:0]           o_upto_mask,
    output logic [LANES-1:0]           o_wb_keep
);

    // o_upto_mask covers lanes up to and including the first excepting lane.
    always_comb begin
        logic w_found;
        w_found     = 1'b0;
        o_except_oh = '0;
        o_upto_mask = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (!w_found) begin
                o_upto_mask[k] = 1'b1;
                if (i_valid[k] && i_except_valid[k]) begin
                    w_found        = 1'b1;
                    o_except_oh[k] = 1'b1;
                end
            end
        end
        o_except_found = w_found;
    end

    always_comb begin
        o_wb_keep = i_cand;
        for (int unsigned k = 0; k < LANES; k++) begin
            for (int unsigned j = k + 1; j < LANES; j++) begin
                if (i_cand[j] &&
                    (i_rd_idx[j*REG_IDX_W +: REG_IDX_W] == i_rd_idx[k*REG_IDX_W +: REG_IDX_W]))
                    o_wb_keep[k] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/writeback_multi.sv
// N-lane in-order writeback/commit: regfile writes, oldest-exception flush/redirect,
// post-flush shadow and cycle/retire counters. All outputs registered.
module writeback_multi
    import wb_pkg::*;
#(
    parameter int unsigned LANES        = 2,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned REG_IDX_W    = 5,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 64
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [LANES-1:0]             i_valid,
    input  logic [LANES*XLEN-1:0]        i_pc,
    input  logic [LANES-1:0]             i_half,
    input  logic [LANES-1:0]             i_except_valid,
    input  logic [LANES*5-1:0]           i_except_code,
    input  logic [LANES*REG_IDX_W-1:0]   i_rd_idx,
    input  logic [LANES*2-1:0]           i_rd_sel,
    input  logic [LANES*XLEN-1:0]        i_data,
    output logic [LANES-1:0]             o_wb_valid,
    output logic [LANES*REG_IDX_W-1:0]   o_wb_idx,
    output logic [LANES*XLEN-1:0]        o_wb_data,
    output logic                         o_flush,
    output logic                         o_pc_alter,
    output logic [XLEN-1:0]              o_pc,
    output logic [$clog2(LANES+1)-1:0]   o_retire_num,
    output logic [CNT_W-1:0]             o_cycle_count,
    output logic [CNT_W-1:0]             o_retire_count
);

    localparam int unsigned RN_W = $clog2(LANES + 1);
    localparam int unsigned SH_W = $clog2(FLUSH_CYCLES + 1);

    logic [SH_W-1:0]                r_shadow;
    logic                           w_active;
    logic [LANES-1:0][XLEN-1:0]     w_seq_pc;
    logic [LANES-1:0]               w_live;
    logic [LANES-1:0]               w_retire;
    logic [LANES-1:0]               w_cand;
    logic [LANES-1:0]               w_keep;
    logic [LANES-1:0]               w_wb_valid;
    logic [LANES*REG_IDX_W-1:0]     w_wb_idx;
    logic [LANES*XLEN-1:0]          w_wb_data;
    logic                           w_except_found;
    logic [LANES-1:0]               w_except_oh;
    logic [LANES-1:0]               w_upto;
    logic [4:0]                     w_e_code;
    logic [XLEN-1:0]                w_e_data;
    logic [XLEN-1:0]                w_e_seq_pc;
    logic                           w_flush;
    logic [XLEN-1:0]                w_redirect_pc;
    logic [RN_W-1:0]                w_retire_num;

    assign w_active = (r_shadow == '0);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [1:0] w_sel;
        assign w_sel       = i_rd_sel[k*2 +: 2];
        assign w_seq_pc[k] = i_pc[k*XLEN +: XLEN] + (i_half[k] ? XLEN'(2) : XLEN'(4));
        assign w_live[k]   = w_active & i_valid[k] & w_upto[k];
        // Lanes before the excepting one never carry an exception, so this only gates lane e.
        assign w_retire[k] = w_live[k] &
                             (~i_except_valid[k] | is_retiring_except(i_except_code[k*5 +: 5]));
        assign w_cand[k]   = w_retire[k] & (i_rd_idx[k*REG_IDX_W +: REG_IDX_W] != '0) &
                             ((w_sel == RD_REG) || (w_sel == RD_REG_AND_PC));
        assign w_wb_valid[k] = w_cand[k] & w_keep[k];
        assign w_wb_idx[k*REG_IDX_W +: REG_IDX_W] =
            w_wb_valid[k] ? i_rd_idx[k*REG_IDX_W +: REG_IDX_W] : '0;
        assign w_wb_data[k*XLEN +: XLEN] =
            !w_wb_valid[k]           ? '0 :
            (w_sel == RD_REG_AND_PC) ? w_seq_pc[k] : i_data[k*XLEN +: XLEN];
    end

    wb_lane_sel #(
        .LANES     (LANES),
        .REG_IDX_W (REG_IDX_W)
    ) u_lane_sel (
        .i_valid        (i_valid),
        .i_except_valid (i_except_valid),
        .i_rd_idx       (i_rd_idx),
        .i_cand         (w_cand),
        .o_except_found (w_except_found),
        .o_except_oh    (w_except_oh),
        .o_upto_mask    (w_upto),
        .o_wb_keep      (w_keep)
    );

    always_comb begin
        w_e_code     = '0;
        w_e_data     = '0;
        w_e_seq_pc   = '0;
        w_retire_num = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (w_except_oh[k]) begin
                w_e_code   = i_except_code[k*5 +: 5];
                w_e_data   = i_data[k*XLEN +: XLEN];
                w_e_seq_pc = w_seq_pc[k];
            end
            w_retire_num = w_retire_num + RN_W'(w_retire[k]);
        end
    end

    assign w_flush       = w_active & w_except_found;
    assign w_redirect_pc = is_mispred(w_e_code) ? w_e_data : w_e_seq_pc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shadow       <= '0;
            o_wb_valid     <= '0;
            o_wb_idx       <= '0;
            o_wb_data      <= '0;
            o_flush        <= 1'b0;
            o_pc_alter     <= 1'b0;
            o_pc           <= '0;
            o_retire_num   <= '0;
            o_cycle_count  <= '0;
            o_retire_count <= '0;
        end else begin
            if (w_flush)
                r_shadow <= SH_W'(FLUSH_CYCLES);
            else if (r_shadow != '0)
                r_shadow <= r_shadow - 1'b1;
            o_wb_valid     <= w_wb_valid;
            o_wb_idx       <= w_wb_idx;
            o_wb_data      <= w_wb_data;
            o_flush        <= w_flush;
            o_pc_alter     <= w_flush;
            o_pc           <= w_flush ? w_redirect_pc : '0;
            o_retire_num   <= w_retire_num;
            o_cycle_count  <= o_cycle_count + 1'b1;
            o_retire_count <= o_retire_count + CNT_W'(w_retire_num);
        end
    end

endmodule

// File: tb/tb_writeback_multi.sv
// Directed self-checking bench for writeback_multi (LANES=2, FLUSH_CYCLES=3).
module tb_writeback_multi;
    import wb_pkg::*;

    localparam int unsigned LANES = 2;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned RIW   = 5;
    localparam int unsigned FC    = 3;
    localparam int unsigned CW    = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [LANES-1:0]       valid, half, exv;
    logic [LANES*XLEN-1:0]  pc, data;
    logic [LANES*5-1:0]     code;
    logic [LANES*RIW-1:0]   rd;
    logic [LANES*2-1:0]     sel;
    logic [LANES-1:0]       wb_valid;
    logic [LANES*RIW-1:0]   wb_idx;
    logic [LANES*XLEN-1:0]  wb_data;
    logic                   flush, pc_alter;
    logic [XLEN-1:0]        opc;
    logic [1:0]             retire_num;
    logic [CW-1:0]          cyc_cnt, ret_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    longint unsigned exp_cyc = 0;
    longint unsigned exp_ret = 0;

    always #5 clk = ~clk;

    writeback_multi #(
        .LANES        (LANES),
        .XLEN         (XLEN),
        .REG_IDX_W    (RIW),
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_valid        (valid),
        .i_pc           (pc),
        .i_half         (half),
        .i_except_valid (exv),
        .i_except_code  (code),
        .i_rd_idx       (rd),
        .i_rd_sel       (sel),
        .i_data         (data),
        .o_wb_valid     (wb_valid),
        .o_wb_idx       (wb_idx),
        .o_wb_data      (wb_data),
        .o_flush        (flush),
        .o_pc_alter     (pc_alter),
        .o_pc           (opc),
        .o_retire_num   (retire_num),
        .o_cycle_count  (cyc_cnt),
        .o_retire_count (ret_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        valid = '0; half = '0; exv = '0; pc = '0; data = '0; code = '0; rd = '0; sel = '0;
    endtask

    task automatic set_lane(input int unsigned k, input logic [31:0] l_pc, input logic l_half,
                            input logic l_exv, input logic [4:0] l_code, input logic [4:0] l_rd,
                            input logic [1:0] l_sel, input logic [31:0] l_data);
        valid[k]          = 1'b1;
        pc[k*XLEN +: XLEN] = l_pc;
        half[k]           = l_half;
        exv[k]            = l_exv;
        code[k*5 +: 5]    = l_code;
        rd[k*RIW +: RIW]  = l_rd;
        sel[k*2 +: 2]     = l_sel;
        data[k*XLEN +: XLEN] = l_data;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        exp_cyc = rst ? 0 : exp_cyc + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_cyc"}, cyc_cnt, exp_cyc);
        check({tag, "_ret"}, ret_cnt, exp_ret);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_wbv"},   64'(wb_valid), 64'(0));
        check({tag, "_flush"}, 64'(flush), 64'(0));
        check({tag, "_rnum"},  64'(retire_num), 64'(0));
        check_counters(tag);
    endtask

    task automatic two_plain();
        idle();
        set_lane(0, 32'h100, 1'b0, 1'b0, 5'd0, 5'd3, RD_REG, 32'h11);
        set_lane(1, 32'h104, 1'b0, 1'b0, 5'd0, 5'd4, RD_REG, 32'h22);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step(); step();
        check("rst_wbv",   64'(wb_valid), 64'(0));
        check("rst_flush", 64'(flush), 64'(0));
        check("rst_alter", 64'(pc_alter), 64'(0));
        check("rst_pc",    64'(opc), 64'(0));
        check("rst_rnum",  64'(retire_num), 64'(0));
        check_counters("rst");
        rst = 1'b0;

        // Two plain retirements
        two_plain();
        step();
        exp_ret += 2;
        check("t1_wbv",   64'(wb_valid), 64'(2'b11));
        check("t1_idx",   64'(wb_idx), 64'({5'd4, 5'd3}));
        check("t1_data",  64'(wb_data), {32'h22, 32'h11});
        check("t1_rnum",  64'(retire_num), 64'(2));
        check("t1_flush", 64'(flush), 64'(0));
        check_counters("t1");

        // Lane0 mispredict, lane1 squashed; shadow swallows the next FC cycles
        idle();
        set_lane(0, 32'h1000, 1'b0, 1'b1, EXCEPT_MISPRED, 5'd0, RD_NONE, 32'h8000_0100);
        set_lane(1, 32'h1004, 1'b0, 1'b0, 5'd0, 5'd5, RD_REG, 32'h55);
        step();
        exp_ret += 1;
        check("t2_flush", 64'(flush), 64'(1));
        check("t2_alter", 64'(pc_alter), 64'(1));
        check("t2_pc",    64'(opc), 64'h8000_0100);
        check("t2_wbv",   64'(wb_valid), 64'(0));
        check("t2_rnum",  64'(retire_num), 64'(1));
        check_counters("t2");
        two_plain();
        for (int i = 0; i < int'(FC); i++) begin
            step();
            check_quiet($sformatf("t2_sh%0d", i));
        end
        step();
        exp_ret += 2;
        check("t2_resume_wbv", 64'(wb_valid), 64'(2'b11));
        check("t2_resume_rnum", 64'(retire_num), 64'(2));
        check_counters("t2_resume");

        // Lane1 illegal instruction: lane0 writes, redirect to pc1+4
        idle();
        set_lane(0, 32'h2000, 1'b0, 1'b0, 5'd0, 5'd6, RD_REG, 32'h66);
        set_lane(1, 32'h2004, 1'b0, 1'b1, EXCEPT_ILLEGAL_INSTR, 5'd8, RD_REG, 32'h88);
        step();
        exp_ret += 1;
        check("t3_wbv",   64'(wb_valid), 64'(2'b01));
        check("t3_data0", 64'(wb_data[31:0]), 64'h66);
        check("t3_rnum",  64'(retire_num), 64'(1));
        check("t3_flush", 64'(flush), 64'(1));
        check("t3_pc",    64'(opc), 64'h2008);
        idle();
        for (int i = 0; i < int'(FC); i++) step();
        check_counters("t3_after");

        // Same-cycle WAW: younger lane wins
        idle();
        set_lane(0, 32'h300, 1'b0, 1'b0, 5'd0, 5'd7, RD_REG, 32'hA);
        set_lane(1, 32'h304, 1'b0, 1'b0, 5'd0, 5'd7, RD_REG, 32'hB);
        step();
        exp_ret += 2;
        check("t4_wbv",   64'(wb_valid), 64'(2'b10));
        check("t4_data1", 64'(wb_data[63:32]), 64'hB);
        check("t4_rnum",  64'(retire_num), 64'(2));

        // Link value wraps; rd=0 never writes
        idle();
        set_lane(0, 32'hFFFF_FFFE, 1'b1, 1'b0, 5'd0, 5'd9, RD_REG_AND_PC, 32'h1234);
        set_lane(1, 32'h0000_0000, 1'b0, 1'b0, 5'd0, 5'd0, RD_REG, 32'h77);
        step();
        exp_ret += 2;
        check("t5_wbv",   64'(wb_valid), 64'(2'b01));
        check("t5_data0", 64'(wb_data[31:0]), 64'h0);
        check("t5_rnum",  64'(retire_num), 64'(2));

        // ECALL retires and may write its link value; redirect to seq pc
        idle();
        set_lane(0, 32'h3000, 1'b0, 1'b1, EXCEPT_ECALL_FROM_U, 5'd10, RD_REG_AND_PC, 32'h0);
        set_lane(1, 32'h3004, 1'b0, 1'b0, 5'd0, 5'd11, RD_REG, 32'h99);
        step();
        exp_ret += 1;
        check("t6_wbv",   64'(wb_valid), 64'(2'b01));
        check("t6_data0", 64'(wb_data[31:0]), 64'h3004);
        check("t6_pc",    64'(opc), 64'h3004);
        check("t6_rnum",  64'(retire_num), 64'(1));
        check_counters("t6");

        // Reset during the shadow; first post-reset cycle accepts input
        idle();
        set_lane(0, 32'h4000, 1'b0, 1'b1, EXCEPT_MISPRED, 5'd0, RD_NONE, 32'h4400);
        for (int i = 0; i < int'(FC); i++) step();
        set_lane(0, 32'h4000, 1'b0, 1'b1, EXCEPT_MISPRED, 5'd0, RD_NONE, 32'h4400);
        step();
        exp_ret += 1;
        check("t7_flush", 64'(flush), 64'(1));
        two_plain();
        rst = 1'b1;
        step();
        exp_ret = 0;
        check("t7_rst_flush", 64'(flush), 64'(0));
        check("t7_rst_pc",    64'(opc), 64'(0));
        check_quiet("t7_rst");
        rst = 1'b0;
        step();
        exp_ret += 2;
        check("t7_post_wbv",  64'(wb_valid), 64'(2'b11));
        check("t7_post_rnum", 64'(retire_num), 64'(2));
        check_counters("t7_post");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
